// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control FSM.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned LAP_W       = 4;
  localparam int unsigned MAX_LAP_DEF = 9;

  localparam logic [DIGIT_W-1:0] FULL_MIN1  = 4'd9;
  localparam logic [DIGIT_W-1:0] FULL_SEC10 = 4'd5;
  localparam logic [DIGIT_W-1:0] FULL_SEC1  = 4'd9;
  localparam logic [DIGIT_W-1:0] FULL_MS100 = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_STOP,
    S_FULL
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; one pulse per press.
module btn_edge (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button handling, run/lap/stop FSM, lap capture and full-scale stop.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_LAP = MAX_LAP_DEF
) (
  input  logic               clk_10Hz,
  input  logic               clr_n,
  input  logic               btn_ss,
  input  logic               btn_lr,
  input  logic [DIGIT_W-1:0] min1,
  input  logic [DIGIT_W-1:0] sec10,
  input  logic [DIGIT_W-1:0] sec1,
  input  logic [DIGIT_W-1:0] ms100,
  output logic               sw_en,
  output logic               sw_clr,
  output logic [DIGIT_W-1:0] disp_min1,
  output logic [DIGIT_W-1:0] disp_sec10,
  output logic [DIGIT_W-1:0] disp_sec1,
  output logic [DIGIT_W-1:0] disp_ms100,
  output logic [LAP_W-1:0]   lap_cnt,
  output logic               full
);

  state_t             r_state;
  logic [LAP_W-1:0]   r_lap_cnt;
  logic [DIGIT_W-1:0] r_lap_min1;
  logic [DIGIT_W-1:0] r_lap_sec10;
  logic [DIGIT_W-1:0] r_lap_sec1;
  logic [DIGIT_W-1:0] r_lap_ms100;

  logic w_ss_p;
  logic w_lr_p;
  logic w_at_full;

  btn_edge u_ss_edge (
    .clk     (clk_10Hz),
    .i_rst_n (clr_n),
    .i_btn   (btn_ss),
    .o_pulse (w_ss_p)
  );

  btn_edge u_lr_edge (
    .clk     (clk_10Hz),
    .i_rst_n (clr_n),
    .i_btn   (btn_lr),
    .o_pulse (w_lr_p)
  );

  assign w_at_full = (min1 == FULL_MIN1) && (sec10 == FULL_SEC10) &&
                     (sec1 == FULL_SEC1) && (ms100 == FULL_MS100);

  // Full scale outranks buttons; start/stop outranks lap/reset.
  always_ff @(posedge clk_10Hz) begin
    if (!clr_n) begin
      r_state     <= S_IDLE;
      r_lap_cnt   <= '0;
      r_lap_min1  <= '0;
      r_lap_sec10 <= '0;
      r_lap_sec1  <= '0;
      r_lap_ms100 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ss_p) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_at_full) begin
            r_state <= S_FULL;
          end else if (w_ss_p) begin
            r_state <= S_STOP;
          end else if (w_lr_p) begin
            r_state     <= S_LAP;
            r_lap_min1  <= min1;
            r_lap_sec10 <= sec10;
            r_lap_sec1  <= sec1;
            r_lap_ms100 <= ms100;
            if (r_lap_cnt != LAP_W'(MAX_LAP)) r_lap_cnt <= r_lap_cnt + LAP_W'(1);
          end
        end
        S_LAP: begin
          if (w_at_full)   r_state <= S_FULL;
          else if (w_ss_p) r_state <= S_STOP;
          else if (w_lr_p) r_state <= S_RUN;
        end
        S_STOP: begin
          if (w_ss_p) begin
            r_state <= S_RUN;
          end else if (w_lr_p) begin
            r_state   <= S_IDLE;
            r_lap_cnt <= '0;
          end
        end
        S_FULL: begin
          if (w_lr_p) begin
            r_state   <= S_IDLE;
            r_lap_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Enable is gated by full scale so the counter never wraps to 0:00.0.
  assign sw_en   = ((r_state == S_RUN) || (r_state == S_LAP)) && !w_at_full;
  assign sw_clr  = (r_state == S_IDLE);
  assign full    = (r_state == S_FULL);
  assign lap_cnt = r_lap_cnt;

  assign disp_min1  = (r_state == S_LAP) ? r_lap_min1  : min1;
  assign disp_sec10 = (r_state == S_LAP) ? r_lap_sec10 : sec10;
  assign disp_sec1  = (r_state == S_LAP) ? r_lap_sec1  : sec1;
  assign disp_ms100 = (r_state == S_LAP) ? r_lap_ms100 : ms100;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural BCD stopwatch in the loop.
module tb_stopwatch_ctrl;

  logic       clk_10Hz = 1'b0;
  logic       clr_n    = 1'b0;
  logic       btn_ss   = 1'b0;
  logic       btn_lr   = 1'b0;
  logic [3:0] min1     = 4'd0;
  logic [3:0] sec10    = 4'd0;
  logic [3:0] sec1     = 4'd0;
  logic [3:0] ms100    = 4'd0;

  logic       sw_en;
  logic       sw_clr;
  logic [3:0] disp_min1;
  logic [3:0] disp_sec10;
  logic [3:0] disp_sec1;
  logic [3:0] disp_ms100;
  logic [3:0] lap_cnt;
  logic       full;

  int checks   = 0;
  int failures = 0;

  logic [15:0] disp;
  logic [15:0] live;
  logic [15:0] saved;
  logic [3:0]  exp_lap;

  assign disp = {disp_min1, disp_sec10, disp_sec1, disp_ms100};
  assign live = {min1, sec10, sec1, ms100};

  stopwatch_ctrl #(.MAX_LAP(9)) dut (
    .clk_10Hz   (clk_10Hz),
    .clr_n      (clr_n),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .min1       (min1),
    .sec10      (sec10),
    .sec1       (sec1),
    .ms100      (ms100),
    .sw_en      (sw_en),
    .sw_clr     (sw_clr),
    .disp_min1  (disp_min1),
    .disp_sec10 (disp_sec10),
    .disp_sec1  (disp_sec1),
    .disp_ms100 (disp_ms100),
    .lap_cnt    (lap_cnt),
    .full       (full)
  );

  always #5 clk_10Hz = ~clk_10Hz;

  // Stopwatch being controlled: BCD m:ss.d counter that wraps at 9:59.9.
  always @(posedge clk_10Hz) begin
    if (sw_clr === 1'b1) begin
      min1 <= 4'd0; sec10 <= 4'd0; sec1 <= 4'd0; ms100 <= 4'd0;
    end else if (sw_en === 1'b1) begin
      if (ms100 != 4'd9) ms100 <= ms100 + 4'd1;
      else begin
        ms100 <= 4'd0;
        if (sec1 != 4'd9) sec1 <= sec1 + 4'd1;
        else begin
          sec1 <= 4'd0;
          if (sec10 != 4'd5) sec10 <= sec10 + 4'd1;
          else begin
            sec10 <= 4'd0;
            min1  <= (min1 == 4'd9) ? 4'd0 : min1 + 4'd1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_10Hz);
    #1;
  endtask

  // Raw level sampled at edge k, released after it; ends just after edge k+2.
  task automatic press(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    tick(1);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    tick(3);
    clr_n = 1'b1;
    tick(2);
    checks++; if (sw_clr !== 1'b1) begin failures++; $display("FAIL reset_sw_clr got=%b exp=1", sw_clr); end
    checks++; if (sw_en !== 1'b0) begin failures++; $display("FAIL reset_sw_en got=%b exp=0", sw_en); end
    checks++; if (disp !== 16'h0000) begin failures++; $display("FAIL reset_disp got=%h exp=0000", disp); end
    checks++; if (lap_cnt !== 4'd0) begin failures++; $display("FAIL reset_lap got=%0d exp=0", lap_cnt); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
  endtask

  task automatic test_run_stop();
    press(1'b1, 1'b0);
    checks++; if (sw_en !== 1'b1) begin failures++; $display("FAIL start_sw_en got=%b exp=1", sw_en); end
    checks++; if (sw_clr !== 1'b0) begin failures++; $display("FAIL start_sw_clr got=%b exp=0", sw_clr); end
    checks++; if (disp !== 16'h0000) begin failures++; $display("FAIL start_disp got=%h exp=0000", disp); end
    tick(22);
    press(1'b1, 1'b0);
    checks++; if (sw_en !== 1'b0) begin failures++; $display("FAIL stop_sw_en got=%b exp=0", sw_en); end
    checks++; if (disp !== 16'h0025) begin failures++; $display("FAIL stop_disp got=%h exp=0025", disp); end
    tick(5);
    checks++; if (disp !== 16'h0025) begin failures++; $display("FAIL stop_hold got=%h exp=0025", disp); end
  endtask

  task automatic test_lap();
    press(1'b0, 1'b1);
    tick(1);
    checks++; if (sw_clr !== 1'b1) begin failures++; $display("FAIL stop_reset_clr got=%b exp=1", sw_clr); end
    checks++; if (disp !== 16'h0000) begin failures++; $display("FAIL stop_reset_disp got=%h exp=0000", disp); end
    press(1'b1, 1'b0);
    tick(11);
    press(1'b0, 1'b1);
    checks++; if (disp !== 16'h0013) begin failures++; $display("FAIL lap_disp got=%h exp=0013", disp); end
    checks++; if (live !== 16'h0014) begin failures++; $display("FAIL lap_live got=%h exp=0014", live); end
    checks++; if (lap_cnt !== 4'd1) begin failures++; $display("FAIL lap_cnt1 got=%0d exp=1", lap_cnt); end
    checks++; if (sw_en !== 1'b1) begin failures++; $display("FAIL lap_sw_en got=%b exp=1", sw_en); end
    tick(5);
    checks++; if (disp !== 16'h0013) begin failures++; $display("FAIL lap_frozen got=%h exp=0013", disp); end
    checks++; if (live !== 16'h0019) begin failures++; $display("FAIL lap_live2 got=%h exp=0019", live); end
    press(1'b0, 1'b1);
    checks++; if (disp !== 16'h0022) begin failures++; $display("FAIL lap_release_disp got=%h exp=0022", disp); end
    checks++; if (lap_cnt !== 4'd1) begin failures++; $display("FAIL lap_release_cnt got=%0d exp=1", lap_cnt); end
  endtask

  task automatic test_lap_saturate();
    for (int i = 0; i < 10; i++) begin
      exp_lap = (i + 2 > 9) ? 4'd9 : 4'(i + 2);
      press(1'b0, 1'b1);
      checks++; if (lap_cnt !== exp_lap) begin failures++; $display("FAIL lap_sat_%0d got=%0d exp=%0d", i, lap_cnt, exp_lap); end
      press(1'b0, 1'b1);
    end
    checks++; if (sw_en !== 1'b1) begin failures++; $display("FAIL lap_sat_run got=%b exp=1", sw_en); end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1);
    checks++; if (sw_en !== 1'b0) begin failures++; $display("FAIL both_sw_en got=%b exp=0", sw_en); end
    checks++; if (lap_cnt !== 4'd9) begin failures++; $display("FAIL both_lap got=%0d exp=9", lap_cnt); end
    checks++; if (disp !== live) begin failures++; $display("FAIL both_disp got=%h exp=%h", disp, live); end
    saved = live;
    tick(3);
    checks++; if (live !== saved) begin failures++; $display("FAIL both_hold got=%h exp=%h", live, saved); end
    press(1'b0, 1'b1);
    checks++; if (sw_clr !== 1'b1) begin failures++; $display("FAIL stop_idle_clr got=%b exp=1", sw_clr); end
    checks++; if (lap_cnt !== 4'd0) begin failures++; $display("FAIL stop_idle_lap got=%0d exp=0", lap_cnt); end
    tick(1);
    checks++; if (disp !== 16'h0000) begin failures++; $display("FAIL stop_idle_disp got=%h exp=0000", disp); end
  endtask

  task automatic test_hold();
    btn_ss = 1'b1;
    tick(10);
    checks++; if (sw_en !== 1'b1) begin failures++; $display("FAIL hold_sw_en got=%b exp=1", sw_en); end
    btn_ss = 1'b0;
    tick(2);
    checks++; if (sw_en !== 1'b1) begin failures++; $display("FAIL hold_release got=%b exp=1", sw_en); end
  endtask

  task automatic test_clr_mid_lap();
    press(1'b0, 1'b1);
    checks++; if (lap_cnt !== 4'd1) begin failures++; $display("FAIL clr_pre_lap got=%0d exp=1", lap_cnt); end
    clr_n = 1'b0;
    tick(1);
    checks++; if (sw_clr !== 1'b1) begin failures++; $display("FAIL clr_sw_clr got=%b exp=1", sw_clr); end
    checks++; if (sw_en !== 1'b0) begin failures++; $display("FAIL clr_sw_en got=%b exp=0", sw_en); end
    checks++; if (lap_cnt !== 4'd0) begin failures++; $display("FAIL clr_lap got=%0d exp=0", lap_cnt); end
    tick(1);
    checks++; if (disp !== 16'h0000) begin failures++; $display("FAIL clr_disp got=%h exp=0000", disp); end
    clr_n = 1'b1;
    tick(1);
  endtask

  task automatic test_full();
    press(1'b1, 1'b0);
    tick(5998);
    checks++; if (live !== 16'h9598) begin failures++; $display("FAIL full_pre_live got=%h exp=9598", live); end
    checks++; if (sw_en !== 1'b1) begin failures++; $display("FAIL full_pre_en got=%b exp=1", sw_en); end
    tick(1);
    checks++; if (sw_en !== 1'b0) begin failures++; $display("FAIL full_en_drop got=%b exp=0", sw_en); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_early got=%b exp=0", full); end
    tick(1);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
    checks++; if (disp !== 16'h9599) begin failures++; $display("FAIL full_disp got=%h exp=9599", disp); end
    press(1'b1, 1'b0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_ss_ignored got=%b exp=1", full); end
    checks++; if (disp !== 16'h9599) begin failures++; $display("FAIL full_stay got=%h exp=9599", disp); end
    press(1'b0, 1'b1);
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_exit got=%b exp=0", full); end
    checks++; if (sw_clr !== 1'b1) begin failures++; $display("FAIL full_exit_clr got=%b exp=1", sw_clr); end
    tick(1);
    checks++; if (disp !== 16'h0000) begin failures++; $display("FAIL full_exit_disp got=%h exp=0000", disp); end
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_lap();
    test_lap_saturate();
    test_simultaneous();
    test_hold();
    test_clr_mid_lap();
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
